// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first data, bit stuffing, NRZI, EOP.
// Optional byte counter output enabled by defining USB_TX_BYTE_COUNT_EN.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
`ifdef USB_TX_BYTE_COUNT_EN
  ,
  output logic [7:0] tx_byte_cnt
`endif
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;        // raw bit index, or SE0 period index in EOP
  logic [7:0]    sr_q, sr_d;
  logic          last_q, last_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_vld_q, hold_vld_d;
  logic          level_q, level_d;
  logic [2:0]    ones_q, ones_d;
  logic          stuff_q, stuff_d;    // current period carries a stuffed 0
  logic          urun_q, urun_d;      // packet truncated, go to EOP at byte end
  logic          done_q, done_d;
  logic          urun_p_q, urun_p_d;
`ifdef USB_TX_BYTE_COUNT_EN
  logic [7:0]    cnt_q, cnt_d;
`endif

  logic       period_end;
  logic       xfer;
  logic       launch;
  logic       lbit;
  logic       urun_now;
  logic [7:0] nb;
  logic       nb_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      last_q      <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      level_q     <= 1'b1;
      ones_q      <= '0;
      stuff_q     <= 1'b0;
      urun_q      <= 1'b0;
      done_q      <= 1'b0;
      urun_p_q    <= 1'b0;
`ifdef USB_TX_BYTE_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_vld_q  <= hold_vld_d;
      level_q     <= level_d;
      ones_q      <= ones_d;
      stuff_q     <= stuff_d;
      urun_q      <= urun_d;
      done_q      <= done_d;
      urun_p_q    <= urun_p_d;
`ifdef USB_TX_BYTE_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // All line changes are decided on the edge that starts a bit period.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    last_d      = last_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_vld_d  = hold_vld_q;
    level_d     = level_q;
    ones_d      = ones_q;
    stuff_d     = stuff_q;
    urun_d      = urun_q;
    done_d      = 1'b0;
    urun_p_d    = 1'b0;
`ifdef USB_TX_BYTE_COUNT_EN
    cnt_d       = cnt_q;
`endif
    launch      = 1'b0;
    lbit        = 1'b0;
    urun_now    = 1'b0;
    nb          = hold_vld_q ? hold_q : tx_data;
    nb_last     = hold_vld_q ? hold_last_q : tx_last;
    period_end  = (cyc_q == CYC_LAST);
    xfer        = tx_data_valid && tx_data_ready;

    if (xfer && state_q != S_IDLE) begin
      hold_d      = tx_data;
      hold_last_d = tx_last;
      hold_vld_d  = 1'b1;
    end
    if (state_q != S_IDLE)
      cyc_d = period_end ? '0 : cyc_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx_data_valid) begin
          state_d    = S_SYNC;
          sr_d       = tx_data;
          last_d     = tx_last;
          bit_d      = '0;
          cyc_d      = '0;
          stuff_d    = 1'b0;
          urun_d     = 1'b0;
          hold_vld_d = 1'b0;
`ifdef USB_TX_BYTE_COUNT_EN
          cnt_d      = '0;
`endif
          launch     = 1'b1;
          lbit       = 1'b0;
        end
      end
      S_SYNC, S_DATA: begin
        if (period_end) begin
          if (!stuff_q && bit_q == 3'd7 && state_q == S_DATA) begin
`ifdef USB_TX_BYTE_COUNT_EN
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
            if (!last_q && !hold_vld_q && !xfer) begin
              urun_now = 1'b1;
              urun_d   = 1'b1;
              urun_p_d = 1'b1;
            end
          end
          if (!stuff_q && ones_q == 3'd6) begin
            stuff_d = 1'b1;
            launch  = 1'b1;
            lbit    = 1'b0;
          end else begin
            stuff_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d  = bit_q + 3'd1;
              launch = 1'b1;
              lbit   = (state_q == S_SYNC) ? (bit_q == 3'd6) : sr_q[bit_q + 3'd1];
            end else if (state_q == S_SYNC) begin
              state_d = S_DATA;
              bit_d   = '0;
              launch  = 1'b1;
              lbit    = sr_q[0];
            end else if (last_q || urun_q || urun_now) begin
              state_d = S_EOP_SE0;
              bit_d   = '0;
            end else begin
              // next byte comes from the holding register or this edge's transfer
              sr_d       = nb;
              last_d     = nb_last;
              hold_vld_d = 1'b0;
              bit_d      = '0;
              launch     = 1'b1;
              lbit       = nb[0];
            end
          end
        end
      end
      S_EOP_SE0: begin
        if (period_end) begin
          if (bit_q == 3'd1) begin
            state_d = S_EOP_J;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_EOP_J: begin
        if (period_end) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          level_d    = 1'b1;
          ones_d     = '0;
          stuff_d    = 1'b0;
          urun_d     = 1'b0;
          hold_vld_d = 1'b0;
          bit_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones
    if (launch) begin
      level_d = lbit ? level_q : ~level_q;
      ones_d  = lbit ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    tx_busy       = (state_q != S_IDLE);
    tx_data_ready = (state_q == S_IDLE) ||
                    ((state_q == S_SYNC || state_q == S_DATA) && bit_q == 3'd7 &&
                     !stuff_q && !last_q && !hold_vld_q);
    d_plus        = 1'b1;
    d_minus       = 1'b0;
    case (state_q)
      S_SYNC, S_DATA: begin
        d_plus  = level_q;
        d_minus = ~level_q;
      end
      S_EOP_SE0: begin
        d_plus  = 1'b0;
        d_minus = 1'b0;
      end
      default: begin
        d_plus  = 1'b1;
        d_minus = 1'b0;
      end
    endcase
    tx_done     = done_q;
    tx_underrun = urun_p_q;
`ifdef USB_TX_BYTE_COUNT_EN
    tx_byte_cnt = cnt_q;
`endif
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: reset, NRZI/SYNC, stuffing, byte fetch, underrun, EOP timing.
module tb_usb_tx_encoder;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;
`ifdef USB_TX_BYTE_COUNT_EN
  logic [7:0] tx_byte_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int rel   = 0;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_underrun  (tx_underrun)
`ifdef USB_TX_BYTE_COUNT_EN
    ,
    .tx_byte_cnt  (tx_byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    rel += n;
  endtask

  task automatic adv_to(input int t);
    while (rel < t) adv(1);
  endtask

  // capture edge becomes rel 0; bit period k is sampled at rel 8k+4
  task automatic go(input logic [7:0] d, input logic l);
    tx_data       = d;
    tx_last       = l;
    tx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data_valid = 1'b0;
    rel = 0;
  endtask

  task automatic line_seq(input string tag, input logic [31:0] ev, input int n);
    logic b;
    for (int k = 0; k < n; k++) begin
      adv_to(CPB * k + 4);
      b = ev[k];
      chk(tag, {31'd0, d_plus}, {31'd0, b});
      chk({tag, "_dm"}, {31'd0, d_minus}, {31'd0, ~b});
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    tx_data       = d;
    tx_last       = l;
    tx_data_valid = 1'b1;
    adv(1);
    tx_data_valid = 1'b0;
  endtask

  initial begin
    n_rst         = 1'b0;
    tx_data       = '0;
    tx_last       = 1'b0;
    tx_data_valid = 1'b0;
    #12;
    chk("rst_dp",    {31'd0, d_plus},        32'd1);
    chk("rst_dm",    {31'd0, d_minus},       32'd0);
    chk("rst_busy",  {31'd0, tx_busy},       32'd0);
    chk("rst_ready", {31'd0, tx_data_ready}, 32'd1);
    chk("rst_done",  {31'd0, tx_done},       32'd0);
    chk("rst_urun",  {31'd0, tx_underrun},   32'd0);
    n_rst = 1'b1;
    adv(2);

    // single last byte 0xA5
    go(8'hA5, 1'b1);
    chk("a5_busy", {31'd0, tx_busy}, 32'd1);
    chk("a5_rdy0", {31'd0, tx_data_ready}, 32'd0);
    line_seq("a5_line", 32'h0000_362A, 16);
    adv_to(132); chk("a5_se0a_dp", {31'd0, d_plus}, 32'd0); chk("a5_se0a_dm", {31'd0, d_minus}, 32'd0);
    adv_to(140); chk("a5_se0b_dp", {31'd0, d_plus}, 32'd0); chk("a5_se0b_dm", {31'd0, d_minus}, 32'd0);
    adv_to(148); chk("a5_j_dp", {31'd0, d_plus}, 32'd1); chk("a5_j_busy", {31'd0, tx_busy}, 32'd1);
    adv_to(151); chk("a5_done_early", {31'd0, tx_done}, 32'd0);
    adv_to(152);
    chk("a5_done",  {31'd0, tx_done},       32'd1);
    chk("a5_idle",  {31'd0, tx_busy},       32'd0);
    chk("a5_ready", {31'd0, tx_data_ready}, 32'd1);
    adv_to(153); chk("a5_done_pulse", {31'd0, tx_done}, 32'd0);
    adv(2);

    // stuffing on 0xFF: one extra bit period
    go(8'hFF, 1'b1);
    line_seq("ff_line", 32'h0001_E02A, 17);
    adv_to(CPB * 17 + 4); chk("ff_se0", {31'd0, d_plus}, 32'd0);
    adv_to(CPB * 19 + 4); chk("ff_j", {31'd0, d_plus}, 32'd1);
    adv_to(159); chk("ff_done_early", {31'd0, tx_done}, 32'd0);
    adv_to(160); chk("ff_done", {31'd0, tx_done}, 32'd1);
    adv(2);

    // two bytes, second supplied in the middle of byte 1's bit-7 window
    go(8'h01, 1'b0);
    adv_to(55);  chk("two_rdy_s6", {31'd0, tx_data_ready}, 32'd0);
    adv_to(56);  chk("two_rdy_s7", {31'd0, tx_data_ready}, 32'd1);
    adv_to(63);  chk("two_rdy_s7e", {31'd0, tx_data_ready}, 32'd1);
    adv_to(64);  chk("two_rdy_d0", {31'd0, tx_data_ready}, 32'd0);
    adv_to(119); chk("two_rdy_b6", {31'd0, tx_data_ready}, 32'd0);
    adv_to(120); chk("two_rdy_b7", {31'd0, tx_data_ready}, 32'd1);
    adv_to(123);
    push_byte(8'h02, 1'b1);
    chk("two_rdy_drop", {31'd0, tx_data_ready}, 32'd0);
    adv_to(129); chk("two_no_urun", {31'd0, tx_underrun}, 32'd0);
    rel = rel; // keep absolute numbering
    begin
      logic [31:0] ev2;
      ev2 = 32'h0054_AA2A;
      for (int k = 16; k < 24; k++) begin
        logic b;
        adv_to(CPB * k + 4);
        b = ev2[k];
        chk("two_b2_line", {31'd0, d_plus}, {31'd0, b});
      end
    end
    adv_to(184); chk("two_rdy_last", {31'd0, tx_data_ready}, 32'd0);
    adv_to(215); chk("two_done_early", {31'd0, tx_done}, 32'd0);
    adv_to(216); chk("two_done", {31'd0, tx_done}, 32'd1);
    adv(2);

    // underrun: non-last 0x00 with no follow-up byte
    go(8'h00, 1'b0);
    adv_to(120); chk("ur_rdy_b7", {31'd0, tx_data_ready}, 32'd1);
    adv_to(127); chk("ur_pre", {31'd0, tx_underrun}, 32'd0);
    adv_to(128);
    chk("ur_pulse", {31'd0, tx_underrun}, 32'd1);
    chk("ur_se0_dp", {31'd0, d_plus}, 32'd0);
    chk("ur_se0_dm", {31'd0, d_minus}, 32'd0);
    adv_to(129); chk("ur_pulse_end", {31'd0, tx_underrun}, 32'd0);
    adv_to(143); chk("ur_se0_last", {31'd0, d_plus}, 32'd0);
    adv_to(144); chk("ur_j", {31'd0, d_plus}, 32'd1);
    adv_to(152); chk("ur_done", {31'd0, tx_done}, 32'd1);
    adv(2);

`ifdef USB_TX_BYTE_COUNT_EN
    go(8'hAA, 1'b0);
    chk("cnt_start", {24'd0, tx_byte_cnt}, 32'd0);
    adv_to(122);
    push_byte(8'hBB, 1'b0);
    adv_to(130); chk("cnt_one", {24'd0, tx_byte_cnt}, 32'd1);
    adv_to(186);
    push_byte(8'hCC, 1'b1);
    adv_to(280);
    chk("cnt_done", {31'd0, tx_done}, 32'd1);
    chk("cnt_three", {24'd0, tx_byte_cnt}, 32'd3);
    adv(3);
    chk("cnt_hold", {24'd0, tx_byte_cnt}, 32'd3);
    go(8'h00, 1'b1);
    chk("cnt_clear", {24'd0, tx_byte_cnt}, 32'd0);
    adv_to(152);
    adv(2);
`endif

    // reset mid-packet aborts to idle at once
    go(8'hA5, 1'b1);
    adv_to(30);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_dp",    {31'd0, d_plus},        32'd1);
    chk("mid_rst_dm",    {31'd0, d_minus},       32'd0);
    chk("mid_rst_busy",  {31'd0, tx_busy},       32'd0);
    chk("mid_rst_ready", {31'd0, tx_data_ready}, 32'd1);
    adv(3);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adv(CPB);
      chk("post_rst_dp",   {31'd0, d_plus},  32'd1);
      chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);
      chk("post_rst_done", {31'd0, tx_done}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
